decomp_fetch_sequencer: RTL
===========================

// Module: decomp_fetch_sequencer
// PURPOSE
// - Sequences instruction fetch from the compressed code ROM to the CPU fetch stage, replacing the PC-indexed lookup.
// - Tracks the ROM word pointer against the sequential PC stream. Expands dictionary tokens into 1..15 repeated
//   instructions. Hosts a CPU/loader-writable dictionary.
// - Sits between the CPU fetch stage, a 1-cycle-latency synchronous code ROM and the configuration bus.
// PARAMETERS
// ADDR_W      9             ROM word address width
// ROM_WORDS   401           valid code words; pointer == ROM_WORDS means end of code
// DICT_DEPTH  6             dictionary entries, indices 0..DICT_DEPTH-1
// TOKEN_BASE  32'hA         smallest legal token; token t selects entry t-TOKEN_BASE
// PC_STEP     32'd1         PC increment per instruction
// NOP_INSTR   32'h00000013  instruction returned on error/end of code
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       asynchronous active-low reset
// restart      in   1       sync pulse: restart stream at PC 0
// fetch_req    in   1       CPU requests the instruction at fetch_pc
// fetch_pc     in   32      PC of the request (checked, not used for addressing)
// fetch_ready  out  1       request accepted when fetch_req & fetch_ready
// instr_valid  out  1       1-cycle pulse, instr is valid
// instr        out  32      decompressed instruction
// rom_rd       out  1       ROM read strobe
// rom_addr     out  ADDR_W  ROM word address
// rom_data     in   32      ROM data, valid the cycle after rom_rd
// dict_we      in   1       dictionary write strobe
// dict_idx     in   4       entry index; writes with idx>=DICT_DEPTH are ignored
// dict_wdata   in   36      [35:32] repeat count R (0 treated as 1), [31:0] instruction
// seq_err      out  1       sticky: accepted fetch_pc != expected PC
// tok_err      out  1       sticky: token < TOKEN_BASE or index >= DICT_DEPTH
// eoc          out  1       word pointer == ROM_WORDS
// BEHAVIOUR
// - Reset values: state IDLE, word_ptr=0, exp_pc=0, rem=0.
//   Outputs: instr_valid=0, instr=0, rom_rd=0, rom_addr=0, seq_err=0, tok_err=0, eoc=0; dictionary all 0.
// - fetch_ready is 1 in IDLE and EXPAND. It is 0 in READ and in any cycle with restart=1.
// - Every accepted request:
//   - sets seq_err if fetch_pc != exp_pc;
//   - then advances exp_pc += PC_STEP (mod 2^32);
//   - the fetch proceeds sequentially regardless of the mismatch.
// - IDLE, accept:
//   - eoc=1: next cycle instr_valid=1, instr=NOP_INSTR, no rom_rd, stay IDLE.
//   - eoc=0: same cycle rom_rd=1, rom_addr=word_ptr, go READ.
// - READ, rom_data >= 32'h10 (literal): next cycle instr_valid=1, instr=rom_data, word_ptr++, go IDLE.
// - READ, rom_data < 32'h10 (token):
//   - Look up entry E = dict[rom_data-TOKEN_BASE].
//   - Next cycle instr_valid=1, instr=E[31:0].
//   - Latch E[31:0]; set rem = max(E[35:32],1)-1.
//   - rem==0: word_ptr++, go IDLE. Otherwise go EXPAND with word_ptr held.
// - READ, illegal token: instr=NOP_INSTR, tok_err=1, word_ptr++, go IDLE.
// - Latency: literal or token head is accept+2 cycles; each EXPAND repeat is accept+1 cycle.
// - EXPAND, accept: next cycle instr_valid=1 with the latched instr, rem--.
//   When rem reaches 0: word_ptr++, go IDLE.
// - The latched expansion is unaffected by dictionary writes to its entry.
//   A write and a lookup of the same index in the same cycle: the lookup sees the old value.
// - word_ptr saturates at ROM_WORDS. eoc is combinational (word_ptr == ROM_WORDS).
// - restart has priority over everything:
//   - next cycle state=IDLE, word_ptr=0, exp_pc=0, rem=0;
//   - seq_err and tok_err cleared, instr_valid=0;
//   - an in-flight ROM read is discarded and the dictionary is kept.
// - Async reset mid-READ or mid-EXPAND: immediate return to reset values; no instr_valid is produced.
// - fetch_req while fetch_ready=0 is not accepted. The CPU holds it until accepted.
// TESTING
// - ROM {32'h20000001, 32'h30000002}, sequential PCs 0,1 -> instr 20000001@acc+2, 30000002@acc+2; seq_err=0.
// - dict[0]={4'd3,32'hAAAA0000}, ROM {32'hA, 32'h40000000}, PCs 0..3 -> AAAA0000 x3 (first acc+2, then acc+1), 40000000; rom_rd pulses=2.
// - ROM {32'h5} -> instr=NOP_INSTR, tok_err=1, word_ptr advances to 1.
// - dict write to idx 0 during EXPAND of idx 0 -> remaining repeats keep old value; next token 0x A uses new value.
// - request fetch_pc=5 when exp_pc=1 -> seq_err=1 sticky; instruction for word 1 still returned; restart clears seq_err.
// - restart (or rst_n low) asserted in READ -> no instr_valid; next fetch at PC 0 reads rom_addr=0. ROM_WORDS reached -> eoc=1, NOP returned, no rom_rd.

Source files
------------

// File: rtl/decomp_fetch_sequencer.sv
// Fetch sequencer between the CPU fetch stage, a 1-cycle synchronous code ROM
// and a writable token dictionary. Literal ROM words pass straight through;
// token words expand into 1..15 copies of a dictionary instruction.
//
// Handshake: a request is accepted on a rising edge where fetch_req and
// fetch_ready are both 1. The CPU holds fetch_req/fetch_pc stable until that
// edge. Each accepted request yields exactly one instr_valid pulse later on
// (two cycles after acceptance for a ROM read, one cycle for an expansion
// repeat or an end-of-code NOP). restart or rst_n drop all outstanding work.
module decomp_fetch_sequencer #(
    parameter int          ADDR_W     = 9,
    parameter int          ROM_WORDS  = 401,
    parameter int          DICT_DEPTH = 6,
    parameter logic [31:0] TOKEN_BASE = 32'hA,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              dict_we,
    input  logic [3:0]        dict_idx,
    input  logic [35:0]       dict_wdata,
    output logic              seq_err,
    output logic              tok_err,
    output logic              eoc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        EXPAND = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] END_PTR = ADDR_W'(ROM_WORDS);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] word_ptr;
    logic [31:0]       exp_pc;
    logic [3:0]        rem;
    logic [31:0]       exp_instr;
    logic [35:0]       dict [DICT_DEPTH];

    logic              accept;
    logic              is_token;
    logic              tok_legal;
    logic [31:0]       tok_off;
    logic [35:0]       entry;
    logic [3:0]        rep_cnt;

    // Handshake, ROM strobe and token decode of the word returned by the ROM.
    always_comb begin
        fetch_ready = ((state == IDLE) || (state == EXPAND)) && !restart;
        accept      = fetch_req && fetch_ready;
        eoc         = (word_ptr == END_PTR);
        rom_rd      = accept && (state == IDLE) && !eoc;
        rom_addr    = word_ptr;
        is_token    = (rom_data < 32'h10);
        tok_off     = rom_data - TOKEN_BASE;
        tok_legal   = (rom_data >= TOKEN_BASE) && (tok_off < DICT_DEPTH);
        entry       = '0;
        for (int i = 0; i < DICT_DEPTH; i++) begin
            if (tok_off == 32'(i)) begin
                entry = dict[i];
            end
        end
        // A repeat count of zero still emits the instruction once.
        rep_cnt = (entry[35:32] == 4'd0) ? 4'd1 : entry[35:32];
    end

    // Next-state logic; restart always returns to IDLE.
    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && !eoc) state_next = READ;
                READ:    if (is_token && tok_legal && (rep_cnt != 4'd1)) state_next = EXPAND;
                         else state_next = IDLE;
                EXPAND:  if (accept && (rem == 4'd1)) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register, stream pointers, output registers and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_ptr    <= '0;
            exp_pc      <= '0;
            rem         <= '0;
            exp_instr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            seq_err     <= 1'b0;
            tok_err     <= 1'b0;
        end else if (restart) begin
            state       <= IDLE;
            word_ptr    <= '0;
            exp_pc      <= '0;
            rem         <= '0;
            instr_valid <= 1'b0;
            seq_err     <= 1'b0;
            tok_err     <= 1'b0;
        end else begin
            state       <= state_next;
            instr_valid <= 1'b0;
            if (accept) begin
                exp_pc <= exp_pc + PC_STEP;
                if (fetch_pc != exp_pc) seq_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept && eoc) begin
                        instr_valid <= 1'b1;
                        instr       <= NOP_INSTR;
                    end
                end
                READ: begin
                    instr_valid <= 1'b1;
                    if (!is_token) begin
                        instr <= rom_data;
                        if (!eoc) word_ptr <= word_ptr + 1'b1;
                    end else if (!tok_legal) begin
                        instr   <= NOP_INSTR;
                        tok_err <= 1'b1;
                        if (!eoc) word_ptr <= word_ptr + 1'b1;
                    end else begin
                        instr     <= entry[31:0];
                        exp_instr <= entry[31:0];
                        rem       <= rep_cnt - 4'd1;
                        // The pointer stays on the token word until its last repeat.
                        if ((rep_cnt == 4'd1) && !eoc) word_ptr <= word_ptr + 1'b1;
                    end
                end
                EXPAND: begin
                    if (accept) begin
                        instr_valid <= 1'b1;
                        instr       <= exp_instr;
                        rem         <= rem - 4'd1;
                        if ((rem == 4'd1) && !eoc) word_ptr <= word_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Dictionary storage; lookups in the same cycle as a write see the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DICT_DEPTH; i++) dict[i] <= '0;
        end else if (dict_we) begin
            for (int i = 0; i < DICT_DEPTH; i++) begin
                if ({28'd0, dict_idx} == 32'(i)) dict[i] <= dict_wdata;
            end
        end
    end

endmodule
